// File: rtl/cache_line_refill_engine.sv
// Cache miss handler: writes back a dirty victim line word by word, then refills
// a full line from the 4B memory port and hands it over as one wide line.
//
// state | meaning
// IDLE  | waiting for a miss request
// WB    | writing victim words back and collecting write acks
// RD    | issuing refill reads and collecting read data (any order)
// DONE  | refilled line presented until the consumer takes it
module cache_line_refill_engine #(
    parameter int p_num_words  = 16,
    parameter int p_word_nbits = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                req_val,
    output logic                                req_rdy,
    input  logic                                req_evict,
    input  logic [31:0]                         req_evict_addr,
    input  logic [p_num_words*p_word_nbits-1:0] req_evict_data,
    input  logic [31:0]                         req_refill_addr,
    output logic                                memreq_val,
    input  logic                                memreq_rdy,
    output logic [76:0]                         memreq_msg,
    input  logic                                memresp_val,
    output logic                                memresp_rdy,
    input  logic [46:0]                         memresp_msg,
    output logic                                line_val,
    input  logic                                line_rdy,
    output logic [p_num_words*p_word_nbits-1:0] line_data,
    output logic                                resp_err
);
    localparam int c_line_nbits = p_num_words * p_word_nbits;
    localparam int c_idx_nbits  = $clog2(p_num_words);
    localparam int c_cnt_nbits  = c_idx_nbits + 1;
    localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_words);
    localparam logic [c_cnt_nbits-1:0] c_last = c_cnt_nbits'(p_num_words - 1);
    localparam logic [31:0] c_line_mask  = ~32'(c_line_nbits / 8 - 1);
    localparam logic [2:0]  c_type_read  = 3'd0;
    localparam logic [2:0]  c_type_write = 3'd1;

    typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;
    state_t state, state_next;

    logic [c_cnt_nbits-1:0]  send_cnt, ack_cnt;
    logic [p_num_words-1:0]  arrived;
    logic [31:0]             evict_base, refill_base, send_base;
    logic [c_line_nbits-1:0] evict_line;

    logic [2:0]             resp_type;
    logic [c_idx_nbits-1:0] resp_slot, send_idx;
    logic [31:0]            resp_data;
    logic                   resp_unused;
    logic                   accept, req_hs, wr_ack, rd_new, resp_drop, last_resp;

    assign resp_type   = memresp_msg[46:44];
    assign resp_slot   = memresp_msg[36 +: c_idx_nbits];
    assign resp_data   = memresp_msg[31:0];
    assign resp_unused = ^{memresp_msg[43:36+c_idx_nbits], memresp_msg[35:32]};

    assign accept    = (state == IDLE) && req_val;
    assign req_hs    = memreq_val && memreq_rdy;
    assign wr_ack    = memresp_val && (state == WB) && (resp_type == c_type_write);
    assign rd_new    = memresp_val && (state == RD) && (resp_type == c_type_read)
                       && !arrived[resp_slot];
    // Anything else handshaken while receiving is a wrong-phase or duplicate response.
    assign resp_drop = memresp_val && ((state == WB) || (state == RD)) && !wr_ack && !rd_new;
    assign last_resp = (ack_cnt == c_last);

    assign send_idx  = send_cnt[c_idx_nbits-1:0];
    assign send_base = (state == WB) ? evict_base : refill_base;
    assign memreq_msg = {(state == WB) ? c_type_write : c_type_read,
                         8'(send_cnt),
                         send_base + (32'(send_idx) << 2),
                         2'd0,
                         (state == WB) ? 32'(evict_line[int'(send_idx)*p_word_nbits +: p_word_nbits])
                                       : 32'd0};

    always_comb begin
        state_next  = state;
        req_rdy     = 1'b0;
        memreq_val  = 1'b0;
        memresp_rdy = 1'b0;
        line_val    = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) state_next = req_evict ? WB : RD;
            end
            WB: begin
                memreq_val  = (send_cnt < c_full);
                memresp_rdy = 1'b1;
                if (wr_ack && last_resp) state_next = RD;
            end
            RD: begin
                memreq_val  = (send_cnt < c_full);
                memresp_rdy = 1'b1;
                if (rd_new && last_resp) state_next = DONE;
            end
            DONE: begin
                line_val = 1'b1;
                if (line_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            send_cnt    <= '0;
            ack_cnt     <= '0;
            arrived     <= '0;
            evict_base  <= '0;
            refill_base <= '0;
            evict_line  <= '0;
            line_data   <= '0;
            resp_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                evict_base  <= req_evict_addr & c_line_mask;
                refill_base <= req_refill_addr & c_line_mask;
                evict_line  <= req_evict_data;
                send_cnt    <= '0;
                ack_cnt     <= '0;
                arrived     <= '0;
                resp_err    <= 1'b0;
            end else begin
                if (wr_ack && last_resp) begin
                    send_cnt <= '0;
                    ack_cnt  <= '0;
                end else begin
                    if (req_hs && send_cnt != c_full) send_cnt <= send_cnt + 1'b1;
                    if ((wr_ack || rd_new) && ack_cnt != c_full) ack_cnt <= ack_cnt + 1'b1;
                end
                if (rd_new) begin
                    arrived[resp_slot] <= 1'b1;
                    line_data[int'(resp_slot)*p_word_nbits +: p_word_nbits] <= p_word_nbits'(resp_data);
                end
                if (resp_drop) resp_err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/cache_line_refill_engine.md
Name: cache_line_refill_engine

Overview:
- Memory-side miss handler for the direct-mapped, write-back, write-allocate cache. Sits between the cache control/datapath and the 4B memory port.
- On a miss, the control unit hands it the victim line, if dirty, and the refill address. The engine writes the 16-word victim back to memory, then fetches the 16-word refill line and returns it as one 512-bit line for the M0 data-array write.
- It replaces word-at-a-time sequencing in the control FSM with a single line-level request/response handshake.

Parameters:
- p_num_words, 16, words per cache line.
- p_word_nbits, 32, bits per word (line = p_num_words*p_word_nbits = 512).

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- req_val  in  1  miss request valid
- req_rdy  out  1  engine can accept a miss request
- req_evict  in  1  victim line is dirty; write back before refill
- req_evict_addr  in  32  victim line address; bits [5:0] ignored, treated as 0
- req_evict_data  in  512  victim line; word i at [32i+31:32i]
- req_refill_addr  in  32  refill line address; bits [5:0] ignored
- memreq_val  out  1  memory request valid
- memreq_rdy  in  1  memory request ready
- memreq_msg  out  77  mem_req_4B_t {type, opaque, addr, len, data}
- memresp_val  in  1  memory response valid
- memresp_rdy  out  1  memory response ready
- memresp_msg  in  47  mem_resp_4B_t {type, opaque, test, len, data}
- line_val  out  1  refilled line valid
- line_rdy  in  1  consumer accepts line
- line_data  out  512  refilled line; word i at [32i+31:32i]
- resp_err  out  1  sticky: a dropped response was seen during the current miss

Behaviour:
- Reset: state IDLE; all counters 0; line_data 0; resp_err 0; memreq_val, memresp_rdy and line_val 0; req_rdy 1.
- States: IDLE, WB, RD, DONE.
- IDLE:
  - req_rdy=1.
  - On req_val, latch both addresses (low 6 bits zeroed) and evict data.
  - Clear send/ack counters, clear resp_err, clear the 16-bit arrival mask.
  - Next state is WB if req_evict=1, else RD.
- Outgoing requests (WB and RD):
  - memreq_val = (send_cnt < 16).
  - Request i: addr = base + 4*i; opaque = i (zero-extended to 8 bits); len = 0 (4 bytes).
  - In WB: type = WRITE (1), data = victim word i. In RD: type = READ (0), data = 0.
  - send_cnt increments on memreq_val && memreq_rdy.
  - memreq_msg holds stable while memreq_val=1 and memreq_rdy=0.
- Responses (WB and RD):
  - memresp_rdy = 1 in WB and RD; 0 in IDLE and DONE.
  - A response is counted only if its type matches the phase: WRITE in WB, READ in RD.
  - Mismatched responses are consumed, dropped, and set resp_err.
- Response ordering: arbitrary. Read response data is written to word slot opaque[3:0].
- Duplicate read response for a slot already set in the arrival mask: dropped, sets resp_err, not counted.
- WB to RD: in the cycle the 16th write ack handshakes. Reads never issue before all writes are acked. send_cnt and ack_cnt reset to 0 on this transition.
- RD to DONE: in the cycle the 16th distinct read response handshakes. line_data includes that word from the DONE cycle onward.
- DONE:
  - line_val=1; line_data stable.
  - On line_rdy, go to IDLE. req_rdy rises the following cycle, so there are no back-to-back miss accepts in the same cycle as the line handoff.
- Counters are 5-bit and saturate at 16; no wrap.
- A request and a response may handshake in the same cycle; both take effect.
- Latency:
  - Clean miss with single-cycle memory and rdy always high: line_val rises 18 cycles after the accept cycle.
  - Dirty miss with the same memory: 35 cycles.
- Reset mid-operation:
  - Returns immediately to IDLE and discards all progress.
  - Memory responses still in flight are not accepted, since memresp_rdy=0 in IDLE. Draining them is the memory system's responsibility.
- resp_err holds its value until the next request accept; it does not affect state transitions.

Test Plan:
- Clean miss: refill 0x0000_1040; memory returns word i = 0x1000+i with 1-cycle latency. Expect 16 READ requests at addrs 0x1040..0x107C, opaque 0..15; line_val at cycle 18; line_data word 7 = 0x1007; resp_err=0.
- Dirty miss: evict 0x0000_2000 with word i = 0xA0+i, refill 0x0000_3000. Expect 16 WRITEs first (addr 0x2000+4i, data 0xA0+i), then READs only after the 16th ack; line_val at cycle 35.
- Out-of-order responses plus backpressure: memreq_rdy toggles every other cycle; read responses return in reverse order (opaque 15..0). Expect a correctly placed line with word 0 at [31:0], and no extra requests beyond 16.
- Error handling: inject a WRITE response during RD, then a duplicate opaque 3. Expect both dropped, resp_err=1, DONE still reached only after 16 distinct reads; the next req accept clears resp_err.
- Output stall: hold line_rdy=0 for 5 cycles in DONE. Expect line_val and line_data stable and req_rdy=0; after line_rdy, IDLE next cycle with req_rdy=1.
- Reset mid-WB: assert reset after 5 writes have been sent. Expect all outputs at reset values immediately; a new clean request then completes normally.
